// File: rtl/accel_spi_responder.sv
// SPI mode-0 responder emulating a small 3-axis accelerometer register file.
// All SPI pins are resynchronised into the clk domain and handled through
// edge detection on the synchronised copies only.
module accel_spi_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  output logic [7:0] power_ctl,
  output logic [7:0] filter_ctl,
  output logic       cmd_error,
  output logic       xfer_done
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

  localparam logic [7:0] FilterRst = 8'h13;

  // Synchroniser and edge-detect history
  logic csn_meta_q, csn_sync_q, csn_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // Transaction state
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  edge_cnt_q, edge_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [6:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rd_q, rd_d;
  logic [7:0]  power_q, power_d;
  logic [7:0]  filter_q, filter_d;
  logic [7:0]  snap_x_q, snap_x_d;
  logic [7:0]  snap_y_q, snap_y_d;
  logic [7:0]  snap_z_q, snap_z_d;
  logic        cmd_error_q, cmd_error_d;
  logic        xfer_done_q, xfer_done_d;

  logic       csn_fall, csn_rise, sclk_rise, sclk_fall;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;

  // Two-flop synchronisers plus one history stage for edge detection. The csn
  // chain resets low so a falling edge is only seen after csn was observed
  // high, which keeps the bus ignored until a fresh select after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      csn_meta_q  <= 1'b0;
      csn_sync_q  <= 1'b0;
      csn_prev_q  <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      csn_meta_q  <= spi_csn;
      csn_sync_q  <= csn_meta_q;
      csn_prev_q  <= csn_sync_q;
      sclk_meta_q <= spi_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign csn_fall  = csn_prev_q & ~csn_sync_q;
  assign csn_rise  = ~csn_prev_q & csn_sync_q;
  // SCLK edges only count while the synchronised select is low
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q & ~csn_sync_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q & ~csn_sync_q;
  assign rx_byte   = {rx_q[6:0], mosi_sync_q};

  // Read-side register map, indexed by the current pointer
  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      8'h00:   rd_byte = 8'hAD;
      8'h01:   rd_byte = 8'h1D;
      8'h02:   rd_byte = 8'hF2;
      8'h03:   rd_byte = 8'h01;
      8'h08:   rd_byte = snap_x_q;
      8'h09:   rd_byte = snap_y_q;
      8'h0A:   rd_byte = snap_z_q;
      8'h0B:   rd_byte = 8'h01;
      8'h0E:   rd_byte = {snap_x_q[3:0], 4'h0};
      8'h0F:   rd_byte = {{4{snap_x_q[7]}}, snap_x_q[7:4]};
      8'h10:   rd_byte = {snap_y_q[3:0], 4'h0};
      8'h11:   rd_byte = {{4{snap_y_q[7]}}, snap_y_q[7:4]};
      8'h12:   rd_byte = {snap_z_q[3:0], 4'h0};
      8'h13:   rd_byte = {{4{snap_z_q[7]}}, snap_z_q[7:4]};
      8'h2C:   rd_byte = filter_q;
      8'h2D:   rd_byte = power_q;
      default: rd_byte = 8'h00;
    endcase
  end

  // Transaction FSM: next state, shift registers, register writes and pulses
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    ptr_d       = ptr_q;
    rd_d        = rd_q;
    power_d     = power_q;
    filter_d    = filter_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    snap_z_d    = snap_z_q;
    cmd_error_d = 1'b0;
    xfer_done_d = 1'b0;

    if (csn_rise) begin
      // Deselect aborts from any state; a partial byte is simply dropped
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      edge_cnt_d  = 5'd0;
      miso_d      = 1'b0;
      xfer_done_d = edge_cnt_q[4];
    end else begin
      unique case (state_q)
        StIdle: begin
          if (csn_fall) begin
            state_d    = StCmd;
            bit_cnt_d  = 3'd0;
            edge_cnt_d = 5'd0;
            miso_d     = 1'b0;
            snap_x_d   = x_data;
            snap_y_d   = y_data;
            snap_z_d   = z_data;
            // An SCLK rise landing with the select counts as command bit 7
            if (sclk_rise) begin
              rx_d       = rx_byte;
              bit_cnt_d  = 3'd1;
              edge_cnt_d = 5'd1;
            end
          end
        end
        StCmd, StAddr, StData: begin
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (!edge_cnt_q[4]) edge_cnt_d = edge_cnt_q + 5'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StCmd) begin
                if (rx_byte == 8'h0A) begin
                  state_d = StAddr;
                  rd_d    = 1'b0;
                end else if (rx_byte == 8'h0B) begin
                  state_d = StAddr;
                  rd_d    = 1'b1;
                end else begin
                  state_d     = StIgnore;
                  cmd_error_d = 1'b1;
                end
              end else if (state_q == StAddr) begin
                state_d = StData;
                ptr_d   = rx_byte;
              end else begin
                if (!rd_q) begin
                  case (ptr_q)
                    8'h2C: filter_d = rx_byte;
                    8'h2D: power_d  = rx_byte;
                    8'h1F: begin
                      if (rx_byte == 8'h52) begin
                        power_d  = 8'h00;
                        filter_d = FilterRst;
                      end
                    end
                    default: ;
                  endcase
                end
                ptr_d = ptr_q + 8'd1;
              end
            end
          end else if (sclk_fall && (state_q == StData) && rd_q) begin
            // Byte boundary: present MSB of the addressed register, else shift
            if (bit_cnt_q == 3'd0) begin
              {miso_d, tx_d} = rd_byte;
            end else begin
              miso_d = tx_q[6];
              tx_d   = {tx_q[5:0], 1'b0};
            end
          end
        end
        StIgnore: begin
          if (sclk_rise && !edge_cnt_q[4]) edge_cnt_d = edge_cnt_q + 5'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      edge_cnt_q  <= 5'd0;
      rx_q        <= 8'h00;
      tx_q        <= 7'h00;
      miso_q      <= 1'b0;
      ptr_q       <= 8'h00;
      rd_q        <= 1'b0;
      power_q     <= 8'h00;
      filter_q    <= FilterRst;
      snap_x_q    <= 8'h00;
      snap_y_q    <= 8'h00;
      snap_z_q    <= 8'h00;
      cmd_error_q <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      power_q     <= power_d;
      filter_q    <= filter_d;
      snap_x_q    <= snap_x_d;
      snap_y_q    <= snap_y_d;
      snap_z_q    <= snap_z_d;
      cmd_error_q <= cmd_error_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  // miso is forced low outside a read data phase
  assign spi_miso   = (state_q == StData) && rd_q && miso_q;
  assign power_ctl  = power_q;
  assign filter_ctl = filter_q;
  assign cmd_error  = cmd_error_q;
  assign xfer_done  = xfer_done_q;

endmodule

// File: doc/accel_spi_responder.md
ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 SHALL have port clk  input  1  system clock (pixel_clk domain, 36 MHz); rising-edge only.
REQ-002 SHALL have port rst  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port spi_csn  input  1  chip select from SPI initiator, active-low, asynchronous to clk.
REQ-004 SHALL have port spi_sclk  input  1  SPI clock (mode 0, idle low), asynchronous, <= clk/6.
REQ-005 SHALL have port spi_mosi  input  1  initiator-to-responder data, asynchronous.
REQ-006 SHALL have port spi_miso  output  1  responder-to-initiator data.
REQ-007 SHALL have ports x_data, y_data, z_data  input  8 each  emulated acceleration samples, signed two's complement.
REQ-008 SHALL have port power_ctl  output  8  current POWER_CTL register (0x2D).
REQ-009 SHALL have port filter_ctl  output  8  current FILTER_CTL register (0x2C).
REQ-010 SHALL have port cmd_error  output  1  one-clk pulse on unsupported command byte.
REQ-011 SHALL have port xfer_done  output  1  one-clk pulse when spi_csn rises after a transaction of >=16 SCLK edges.

Function
REQ-012 SHALL pass spi_csn, spi_sclk, spi_mosi through 2-flop synchronizers; edge detection uses synchronized values only.
REQ-013 SHALL sample mosi on detected SCLK rising edge, MSB first; shift miso on detected SCLK falling edge.
REQ-014 SHALL implement FSM states IDLE, CMD, ADDR, DATA, IGNORE.
REQ-015 IDLE -> CMD on synchronized csn falling edge; bit counter cleared; x/y/z snapshotted into holding regs at this edge.
REQ-016 CMD: after 8 rising edges, command 0x0A (write) or 0x0B (read) -> ADDR; any other value -> IGNORE with cmd_error pulse.
REQ-017 ADDR: after 8 rising edges, address latched into 8-bit pointer -> DATA.
REQ-018 DATA read: on the falling edge following the 8th address bit, bit 7 of reg[pointer] appears on miso; remaining bits on subsequent falling edges.
REQ-019 DATA write: after each 8 rising edges, byte written to reg[pointer] if writable (0x2C, 0x2D, 0x1F); other addresses silently discarded.
REQ-020 After each data byte pointer SHALL increment by 1, wrapping 0xFF -> 0x00.
REQ-021 Read map: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=0x01, 0x08=X, 0x09=Y, 0x0A=Z (snapshots), 0x0B=STATUS 0x01, 0x0E/0x10/0x12 = sign-extended low nibble-shifted X/Y/Z ({data[3:0],4'h0}), 0x0F/0x11/0x13 = {4{data[7]},data[7:4]}, 0x2C=filter_ctl, 0x2D=power_ctl, all others 0x00.
REQ-022 Writing 0x52 to 0x1F (SOFT_RESET) SHALL restore power_ctl=0x00, filter_ctl=0x13 at end of that byte.
REQ-023 IGNORE: miso held 0; all SCLK edges ignored until csn rises.
REQ-024 csn rise in any state SHALL return FSM to IDLE next clk; partial bytes discarded (no partial write).
REQ-025 miso SHALL be 0 whenever FSM is not in DATA-read.
REQ-026 SCLK edges while csn high SHALL be ignored.
REQ-027 Snapshot regs SHALL not change during a transaction regardless of x/y/z_data changes.
REQ-028 csn fall and first SCLK edge arriving in the same synchronized clk: csn handled first, edge counted as CMD bit 7.

Reset
REQ-029 On rst: FSM=IDLE, counters=0, pointer=0x00, miso=0, power_ctl=0x00, filter_ctl=0x13, cmd_error=0, xfer_done=0, snapshots=0x00.
REQ-030 rst asserted mid-transaction SHALL abort it; responder ignores bus until next csn falling edge after rst deasserts.

Verification
REQ-031 Read 0x0B,0x00, 4 bytes -> miso returns 0xAD,0x1D,0xF2,0x01; xfer_done pulses once after csn rise.
REQ-032 x=0x7F,y=0x80,z=0x05, read 0x0B,0x08, 3 bytes; change x to 0x00 mid-burst -> 0x7F,0x80,0x05.
REQ-033 Write 0x0A,0x2D,0x02 then read 0x2D -> power_ctl=0x02 and miso 0x02; then write 0x52 to 0x1F -> power_ctl=0x00, filter_ctl=0x13.
REQ-034 Command 0x55 -> one cmd_error pulse, miso stays 0 for following 16 SCLK, no register change.
REQ-035 csn raised after 5 bits of write data byte to 0x2C -> filter_ctl unchanged 0x13; next transaction decodes normally.
REQ-036 Read starting at 0xFF, 2 bytes -> 0x00 then 0xAD (pointer wrap).
